// File: rtl/gamma_edge_encoder.sv
// gamma_edge_encoder
//
// Turns a vector of binary lane values into race-logic rising edges. After a
// value vector is accepted, the block spends one gamma cycle emitting it:
// one SET cycle (gamma_set pulse), GAMMA_CYCLE_WIDTH RUN slots in which lane
// i steps high at slot val[i], then one CLEAR cycle that drops every edge.
// A value at or beyond GAMMA_CYCLE_WIDTH is the null code and never rises.
//
// Ports
//   aclk         clock, all state changes on its rising edge
//   grst_n       asynchronous active-low reset
//   in_valid     a value vector is presented on in_vals
//   in_ready     block is idle and accepts a vector this cycle (state decode)
//   in_vals      lane i value at bits [i*VAL_WIDTH +: VAL_WIDTH]
//   gamma_set    one-cycle pulse at gamma-cycle start (registered)
//   edges        per-lane step outputs (registered)
//   gamma_count  current RUN slot, 0 outside RUN (registered)
//   busy         high in every state except IDLE (registered)

module gamma_edge_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int NUM_LANES         = 2,
  parameter int VAL_WIDTH         = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic                                  aclk,
  input  logic                                  grst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_LANES*VAL_WIDTH-1:0]        in_vals,
  output logic                                  gamma_set,
  output logic [NUM_LANES-1:0]                  edges,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0]  gamma_count,
  output logic                                  busy
);

  localparam int CNT_W = $clog2(GAMMA_CYCLE_WIDTH);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(GAMMA_CYCLE_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SET   = 2'd1,
    S_RUN   = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t                         state_q;
  state_t                         state_d;
  logic [CNT_W-1:0]               t_q;
  logic [CNT_W-1:0]               t_d;
  logic [NUM_LANES*VAL_WIDTH-1:0] vals_q;

  logic                           accept;
  logic                           set_d;
  logic                           busy_d;
  logic [CNT_W-1:0]               count_d;
  logic [NUM_LANES-1:0]           edges_d;

  // A lane is high once the slot has reached its value. Values of
  // GAMMA_CYCLE_WIDTH or more exceed every slot, so null never rises, and
  // because the slot only increases within RUN the step is monotone.
  function automatic logic lane_edge(input logic [VAL_WIDTH-1:0] v,
                                     input logic [CNT_W-1:0]     t);
    return v <= VAL_WIDTH'(t);
  endfunction

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SET;
        end
      end
      S_SET: begin
        state_d = S_RUN;
        t_d     = '0;
      end
      S_RUN: begin
        if (t_q == T_LAST) begin
          state_d = S_CLEAR;
          t_d     = '0;
        end else begin
          t_d = t_q + CNT_W'(1);
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  // On the SET->RUN step the values were already latched at the handshake.
  always_comb begin
    set_d   = (state_d == S_SET);
    busy_d  = (state_d != S_IDLE);
    count_d = (state_d == S_RUN) ? t_d : '0;
    edges_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      edges_d[i] = (state_d == S_RUN) &&
                   lane_edge(vals_q[i*VAL_WIDTH +: VAL_WIDTH], t_d);
    end
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q     <= S_IDLE;
      t_q         <= '0;
      vals_q      <= '0;
      gamma_set   <= 1'b0;
      edges       <= '0;
      gamma_count <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      if (accept) begin
        vals_q <= in_vals;
      end
      gamma_set   <= set_d;
      edges       <= edges_d;
      gamma_count <= count_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_gamma_edge_encoder.sv
// Self-checking bench for gamma_edge_encoder (W=16, two lanes).
// Cycle numbering: the handshake edge is E0, the cycle after it is C1.

module tb_gamma_edge_encoder;

  localparam int G  = 16;
  localparam int NL = 2;
  localparam int VW = $clog2(G) + 1;
  localparam int CW = $clog2(G);
  localparam int OW = 3 + NL + CW;

  logic              aclk;
  logic              grst_n;
  logic              in_valid;
  logic              in_ready;
  logic [NL*VW-1:0]  in_vals;
  logic              gamma_set;
  logic [NL-1:0]     edges;
  logic [CW-1:0]     gamma_count;
  logic              busy;

  typedef struct packed {
    logic [VW-1:0] v1;
    logic [VW-1:0] v0;
  } vec_t;

  vec_t sb[$];

  int n_cmp;
  int n_err;

  logic [OW-1:0] obs [0:G+3];

  gamma_edge_encoder #(
    .GAMMA_CYCLE_WIDTH (G),
    .NUM_LANES         (NL),
    .VAL_WIDTH         (VW)
  ) dut (
    .aclk        (aclk),
    .grst_n      (grst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vals     (in_vals),
    .gamma_set   (gamma_set),
    .edges       (edges),
    .gamma_count (gamma_count),
    .busy        (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [OW-1:0] snap();
    return {in_ready, busy, gamma_set, edges, gamma_count};
  endfunction

  // Waits (bounded) for in_ready at a negedge, then presents a vector and
  // records it in the scoreboard. Leaves in_valid high.
  task automatic start_vector(input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                              output bit ok);
    int n;
    vec_t e;
    n  = 0;
    ok = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL start_timeout: in_ready=%b required=1", in_ready);
      ok = 1'b0;
    end else begin
      in_vals  = {v1, v0};
      in_valid = 1'b1;
      e.v0 = v0;
      e.v1 = v1;
      sb.push_back(e);
    end
  endtask

  // Records C1..C(G+3); optionally scribbles on the inputs during RUN.
  task automatic capture(input bit disturb);
    for (int k = 1; k <= G + 3; k++) begin
      @(negedge aclk);
      obs[k] = snap();
      if (k == 1) in_valid = 1'b0;
      if (disturb && k >= 3 && k <= G) begin
        in_vals  = NL*VW'($urandom);
        in_valid = k[0];
      end
      if (k >= G + 1) in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    bit ok;
    logic [OW-1:0] o;
    // power-on
    repeat (3) @(negedge aclk);
    o = snap();
    n_cmp++;
    if (o !== {1'b1, {(OW-1){1'b0}}}) begin
      n_err++;
      $display("FAIL reset_poweron: got %b required %b", o, {1'b1, {(OW-1){1'b0}}});
    end
    grst_n = 1'b1;
    @(negedge aclk);
    // reset mid-RUN with edges high
    start_vector(0, 0, ok);
    if (ok) begin
      @(negedge aclk);
      in_valid = 1'b0;
      repeat (4) @(negedge aclk);  // now in C5
      n_cmp++;
      if (edges !== 2'b11) begin
        n_err++;
        $display("FAIL reset_pre_edges: got %b required 11", edges);
      end
      #2 grst_n = 1'b0;
      #1 o = snap();
      n_cmp++;
      if (o !== {1'b1, {(OW-1){1'b0}}}) begin
        n_err++;
        $display("FAIL reset_async: got %b required %b", o, {1'b1, {(OW-1){1'b0}}});
      end
      void'(sb.pop_front());
      // handshake attempt while in reset
      in_vals  = {5'd1, 5'd1};
      in_valid = 1'b1;
      repeat (2) @(negedge aclk);
      o = snap();
      n_cmp++;
      if (o !== {1'b1, {(OW-1){1'b0}}}) begin
        n_err++;
        $display("FAIL reset_hold_handshake: got %b required %b", o, {1'b1, {(OW-1){1'b0}}});
      end
      in_valid = 1'b0;
      grst_n   = 1'b1;
      @(negedge aclk);
    end
  endtask

  task automatic test_encode(input string name, input logic [VW-1:0] v0,
                             input logic [VW-1:0] v1, input bit disturb);
    bit ok;
    vec_t e;
    int vv [NL];
    logic [NL-1:0] e_edges;
    logic [CW-1:0] e_cnt;
    logic [OW-1:0] exp_o;
    start_vector(v0, v1, ok);
    if (ok) begin
      capture(disturb);
      e = sb.pop_front();
      vv[0] = int'(e.v0);
      vv[1] = int'(e.v1);
      for (int k = 1; k <= G + 3; k++) begin
        for (int i = 0; i < NL; i++)
          e_edges[i] = (vv[i] < G) && (k >= 2 + vv[i]) && (k <= G + 1);
        e_cnt = (k >= 2 && k <= G + 1) ? CW'(k - 2) : '0;
        exp_o = {(k == G + 3), (k <= G + 2), (k == 1), e_edges, e_cnt};
        n_cmp++;
        if (obs[k] !== exp_o) begin
          n_err++;
          $display("FAIL %s C%0d {ready,busy,set,edges,count}: got %b required %b",
                   name, k, obs[k], exp_o);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses [3];
    int np;
    int cyc;
    int n;
    in_vals  = {5'd4, 5'd2};
    in_valid = 1'b1;
    np  = 0;
    cyc = 0;
    while (np < 3 && cyc < 100) begin
      @(negedge aclk);
      cyc++;
      if (gamma_set) begin
        pulses[np] = cyc;
        np++;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (np != 3) begin
      n_err++;
      $display("FAIL b2b_pulses: got %0d required 3", np);
    end else begin
      for (int j = 1; j < 3; j++) begin
        n_cmp++;
        if (pulses[j] - pulses[j-1] != G + 3) begin
          n_err++;
          $display("FAIL b2b_spacing%0d: got %0d required %0d",
                   j, pulses[j] - pulses[j-1], G + 3);
        end
      end
    end
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge aclk);
      n++;
    end
  endtask

  // Exclusive-max comparator model: the output rises with the later of two
  // edges when they differ; a tie (or two nulls) gives no spike (code G).
  task automatic test_downstream(input string name, input logic [VW-1:0] v0,
                                 input logic [VW-1:0] v1, input int exp_t);
    bit ok;
    int r [NL];
    int res;
    start_vector(v0, v1, ok);
    if (ok) begin
      capture(1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < NL; i++) begin
        r[i] = G;
        for (int k = G + 1; k >= 1; k--)
          if (obs[k][CW + i] === 1'b1 && obs[1][CW+NL] === 1'b1) r[i] = k - 2;
      end
      res = (r[0] != r[1]) ? ((r[0] > r[1]) ? r[0] : r[1]) : G;
      n_cmp++;
      if (res != exp_t) begin
        n_err++;
        $display("FAIL %s xmax: got %0d required %0d (rises %0d,%0d)",
                 name, res, exp_t, r[0], r[1]);
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    grst_n   = 1'b0;
    in_valid = 1'b0;
    in_vals  = '0;
    test_reset();
    test_encode("post_reset", 3, 7, 1'b0);
    test_encode("basic", 3, 7, 1'b0);
    test_encode("bound_0_15", 0, 15, 1'b0);
    test_encode("null_16_31", 16, 31, 1'b0);
    test_encode("gating", 9, 2, 1'b1);
    test_encode("tie", 5, 5, 1'b0);
    test_encode("mixed", 12, 1, 1'b0);
    test_back_to_back();
    test_downstream("xmax_4_9", 4, 9, 9);
    test_downstream("xmax_6_6", 6, 6, G);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
